// File: rtl/uart_pkg.sv
// Shared DUART definitions: transmitter/receiver state encoding, character
// format fields and the parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } tx_state_t;

  localparam logic [1:0] BITS_5 = 2'b00;
  localparam logic [1:0] BITS_6 = 2'b01;
  localparam logic [1:0] BITS_7 = 2'b10;
  localparam logic [1:0] BITS_8 = 2'b11;

  typedef struct packed {
    logic [1:0] bits_sel;
    logic       par_en;
    logic       par_odd;
    logic       stop2;
  } tx_fmt_t;

  // Parity over only the data bits that go on the line, inverted for odd parity.
  function automatic logic char_parity(input logic [7:0] d,
                                       input logic [1:0] bits_sel,
                                       input logic       odd);
    logic [7:0] mask;
    case (bits_sel)
      BITS_5:  mask = 8'h1F;
      BITS_6:  mask = 8'h3F;
      BITS_7:  mask = 8'h7F;
      default: mask = 8'hFF;
    endcase
    return (^(d & mask)) ^ odd;
  endfunction

endpackage

// File: rtl/channel_tx_if.sv
// CPU-side THR write port and status flags of one transmit channel.
// A write is a clk with thr_cs=1 and r_w=0; only the first clk of a held select
// counts, and it is taken only while TxRDY would allow it (enabled, THR empty).
interface channel_tx_if;
  logic [7:0] data;
  logic       r_w;
  logic       thr_cs;
  logic       TxRDY;
  logic       TxEMT;

  modport master (output data, r_w, thr_cs, input TxRDY, TxEMT);
  modport slave  (input data, r_w, thr_cs, output TxRDY, TxEMT);
endinterface

// File: rtl/tx_bit_timer.sv
// Counts baud_tick pulses within one bit time; bit_done marks the tick that
// completes OVERSAMPLE ticks, after which the count restarts for the next bit.
module tx_bit_timer #(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic clear,
  input  logic en,
  input  logic baud_tick,
  output logic bit_done
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

  logic [CW-1:0] cnt;

  assign bit_done = en & baud_tick & (cnt == LAST);

  always_ff @(posedge clk) begin
    if (clear) begin
      cnt <= '0;
    end else if (en & baud_tick) begin
      cnt <= bit_done ? '0 : cnt + CW'(1);
    end
  end
endmodule

// File: rtl/channel_tx.sv
// One DUART transmit channel: THR, write-edge detection, serialising FSM and
// the TxRDY/TxEMT status flags.
module channel_tx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic         clk,
  input  logic         reset,
  channel_tx_if.slave  bus,
  input  logic         TxEN,
  input  logic         TxReset,
  input  logic         baud_tick,
  input  logic [1:0]   bits_sel,
  input  logic         par_en,
  input  logic         par_odd,
  input  logic         stop2,
  output logic         TxD,
  output tx_state_t    state_dbg
);
  tx_state_t  state;
  tx_fmt_t    fmt;
  logic [7:0] thr;
  logic [7:0] shifter;
  logic [2:0] bit_cnt;
  logic       thr_full;
  logic       wr_q;
  logic       par_bit;
  logic       txrdy_q;
  logic       txemt_q;
  logic       bit_done;
  logic       rst_any;
  logic       wr_req;
  logic       accept;
  logic       load;
  logic       last_data;

  assign rst_any   = reset | ~TxReset;
  assign wr_req    = bus.thr_cs & ~bus.r_w;
  assign accept    = wr_req & ~wr_q & TxEN & ~thr_full;
  assign load      = (state == IDLE) & thr_full;
  assign last_data = (bit_cnt == (3'd4 + {1'b0, fmt.bits_sel}));

  assign bus.TxRDY = txrdy_q;
  assign bus.TxEMT = txemt_q;
  assign state_dbg = state;

  tx_bit_timer #(.OVERSAMPLE(OVERSAMPLE)) u_timer (
    .clk       (clk),
    .clear     (rst_any | load),
    .en        (state != IDLE),
    .baud_tick (baud_tick),
    .bit_done  (bit_done)
  );

  always_ff @(posedge clk) begin
    // Edge detect follows the bus even through TxReset so a held select never re-fires.
    wr_q <= reset ? 1'b0 : wr_req;
    if (rst_any) begin
      state    <= IDLE;
      fmt      <= '0;
      thr      <= '0;
      shifter  <= '0;
      bit_cnt  <= '0;
      thr_full <= 1'b0;
      par_bit  <= 1'b0;
      TxD      <= 1'b1;
      txrdy_q  <= 1'b0;
      txemt_q  <= 1'b0;
    end else begin
      txrdy_q <= TxEN & ~thr_full;
      txemt_q <= ~thr_full & (state == IDLE);
      if (accept) begin
        thr      <= bus.data;
        thr_full <= 1'b1;
      end
      case (state)
        IDLE: begin
          TxD <= 1'b1;
          if (thr_full) begin
            thr_full <= 1'b0;
            shifter  <= thr;
            fmt      <= '{bits_sel: bits_sel, par_en: par_en, par_odd: par_odd, stop2: stop2};
            par_bit  <= char_parity(thr, bits_sel, par_odd);
            bit_cnt  <= '0;
            state    <= START;
          end
        end
        START: begin
          TxD <= 1'b0;
          if (bit_done) state <= DATA;
        end
        DATA: begin
          TxD <= shifter[0];
          if (bit_done) begin
            shifter <= {1'b0, shifter[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (last_data) state <= fmt.par_en ? PARITY : STOP1;
          end
        end
        PARITY: begin
          TxD <= par_bit;
          if (bit_done) state <= STOP1;
        end
        STOP1: begin
          TxD <= 1'b1;
          if (bit_done) state <= fmt.stop2 ? STOP2 : IDLE;
        end
        default: begin
          TxD <= 1'b1;
          if (bit_done) state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_channel_tx.sv
// Bench for channel_tx: table of characters/formats with hand-written frames,
// plus sequences for back-to-back, held select, TxEN drop and TxReset abort.
module tb_channel_tx;
  import uart_pkg::*;

  typedef struct {
    logic [7:0]  data;
    logic [1:0]  bits_sel;
    logic        par_en;
    logic        par_odd;
    logic        stop2;
    int          len;
    logic [11:0] frame;   // bits in line order, first bit at [11]
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       TxEN = 1'b1;
  logic       TxReset = 1'b1;
  logic       baud_tick = 1'b0;
  logic [1:0] bits_sel = BITS_8;
  logic       par_en = 1'b0;
  logic       par_odd = 1'b0;
  logic       stop2 = 1'b0;
  logic       TxD;
  tx_state_t  state_dbg;

  channel_tx_if bus ();

  channel_tx #(.OVERSAMPLE(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .TxEN      (TxEN),
    .TxReset   (TxReset),
    .baud_tick (baud_tick),
    .bits_sel  (bits_sel),
    .par_en    (par_en),
    .par_odd   (par_odd),
    .stop2     (stop2),
    .TxD       (TxD),
    .state_dbg (state_dbg)
  );

  // clock and baud tick (one tick every 4 clk)
  always #5 clk = ~clk;

  initial begin
    int bcnt;
    bcnt = 0;
    forever begin
      @(negedge clk);
      bcnt = (bcnt + 1) % 4;
      baud_tick = (bcnt == 0);
    end
  end

  // scoreboard
  logic [11:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cur_len = 10;
  int gap_clks = 0;
  bit abort_flag = 1'b0;

  // Line monitor: centre-samples each frame and compares it with the next expected frame.
  initial begin
    logic [11:0] cap;
    logic [11:0] exp;
    logic        txd_prev;
    int          since;
    txd_prev = 1'b1;
    since = 0;
    forever begin
      @(negedge clk);
      since++;
      if (txd_prev == 1'b1 && TxD == 1'b0) begin
        gap_clks = since;
        cap = '0;
        repeat (31) @(negedge clk);
        for (int i = 0; i < cur_len; i++) begin
          if (i > 0) repeat (64) @(negedge clk);
          cap[11-i] = TxD;
        end
        since = 0;
        if (abort_flag) begin
          abort_flag = 1'b0;
        end else if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame got %b required none", cap);
        end else begin
          exp = exp_q.pop_front();
          checks++;
          if (cap !== exp) begin
            errors++;
            $display("FAIL frame got %b required %b", cap, exp);
          end
        end
      end
      txd_prev = TxD;
    end
  end

  task automatic check1(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h required %0h", name, got, want);
    end
  endtask

  // driver tasks
  task automatic write_thr(input logic [7:0] d, input int hold);
    @(negedge clk);
    bus.data   = d;
    bus.r_w    = 1'b0;
    bus.thr_cs = 1'b1;
    repeat (hold) @(negedge clk);
    bus.thr_cs = 1'b0;
    bus.r_w    = 1'b1;
  endtask

  task automatic set_fmt(input logic [1:0] b, input logic pe, input logic po, input logic s2, input int len);
    bits_sel = b;
    par_en   = pe;
    par_odd  = po;
    stop2    = s2;
    cur_len  = len;
  endtask

  task automatic wait_idle(input string name, output int rdy_hi);
    bit done;
    done = 1'b0;
    rdy_hi = 0;
    for (int n = 0; n < 4000 && !done; n++) begin
      @(negedge clk);
      if (bus.TxRDY === 1'b1) rdy_hi++;
      if (exp_q.size() == 0 && bus.TxEMT === 1'b1) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_idle got TxEMT=%b pending=%0d required TxEMT=1 pending=0",
               name, bus.TxEMT, exp_q.size());
    end
  endtask

  task automatic wait_state(input string name, input tx_state_t target, input int budget);
    bit done;
    done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      @(negedge clk);
      if (state_dbg == target) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s got state=%0d required state=%0d", name, state_dbg, target);
    end
  endtask

  vec_t vecs[8];

  initial begin
    int rdy_hi;
    bit done;

    vecs[0] = '{8'h55, BITS_8, 1'b0, 1'b0, 1'b0, 10, 12'b010101010100};
    vecs[1] = '{8'h41, BITS_7, 1'b1, 1'b1, 1'b1, 11, 12'b010000011110};
    vecs[2] = '{8'hFF, BITS_5, 1'b1, 1'b0, 1'b0,  8, 12'b011111110000};
    vecs[3] = '{8'h2C, BITS_6, 1'b1, 1'b1, 1'b1, 10, 12'b000110101100};
    vecs[4] = '{8'h03, BITS_8, 1'b1, 1'b0, 1'b0, 11, 12'b011000000010};
    vecs[5] = '{8'h80, BITS_7, 1'b0, 1'b0, 1'b0,  9, 12'b000000001000};
    vecs[6] = '{8'hA0, BITS_8, 1'b0, 1'b0, 1'b0, 10, 12'b000000101100};
    vecs[7] = '{8'h0F, BITS_8, 1'b0, 1'b0, 1'b0, 10, 12'b011110000100};

    bus.data   = 8'h00;
    bus.r_w    = 1'b1;
    bus.thr_cs = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    check1("rst_txd", TxD, 1);
    check1("rst_txrdy", bus.TxRDY, 0);
    check1("rst_txemt", bus.TxEMT, 0);
    check1("rst_state", state_dbg, IDLE);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check1("post_rst_txrdy", bus.TxRDY, 1);
    check1("post_rst_txemt", bus.TxEMT, 1);

    // table-driven characters, one at a time
    for (int i = 0; i < 8; i++) begin
      set_fmt(vecs[i].bits_sel, vecs[i].par_en, vecs[i].par_odd, vecs[i].stop2, vecs[i].len);
      exp_q.push_back(vecs[i].frame);
      write_thr(vecs[i].data, 1);
      @(negedge clk);
      check1("wr_txrdy_low", bus.TxRDY, 0);
      check1("wr_txemt_low", bus.TxEMT, 0);
      @(negedge clk);
      check1("xfer_txrdy_high", bus.TxRDY, 1);
      wait_idle("vec", rdy_hi);
    end

    // back-to-back: second start follows first stop; third write dropped
    set_fmt(BITS_8, 1'b0, 1'b0, 1'b0, 10);
    exp_q.push_back(vecs[6].frame);
    exp_q.push_back(vecs[7].frame);
    write_thr(8'hA0, 1);
    repeat (100) @(negedge clk);
    write_thr(8'h0F, 1);
    @(negedge clk);
    check1("b2b_txrdy_full", bus.TxRDY, 0);
    write_thr(8'h77, 1);
    @(negedge clk);
    check1("b2b_txrdy_still", bus.TxRDY, 0);
    check1("b2b_txemt", bus.TxEMT, 0);
    wait_idle("b2b", rdy_hi);
    checks++;
    if (gap_clks < 28 || gap_clks > 36) begin
      errors++;
      $display("FAIL b2b_gap got %0d clk required 28..36 clk", gap_clks);
    end

    // select held 10 clk gives a single character
    exp_q.push_back(12'b011000011100);
    write_thr(8'hC3, 10);
    wait_idle("held_cs", rdy_hi);

    // TxEN falls with THR full: both characters finish, later write ignored
    exp_q.push_back(12'b001011010100);
    exp_q.push_back(12'b011100111100);
    write_thr(8'h5A, 1);
    repeat (100) @(negedge clk);
    write_thr(8'hE7, 1);
    repeat (100) @(negedge clk);
    TxEN = 1'b0;
    done = 1'b0;
    for (int n = 0; n < 2000 && !done; n++) begin
      @(negedge clk);
      if (exp_q.size() == 1) done = 1'b1;
    end
    check1("txen_first_done", done, 1);
    repeat (100) @(negedge clk);
    write_thr(8'h11, 1);
    wait_idle("txen_off", rdy_hi);
    check1("txen_off_txrdy_samples", rdy_hi, 0);
    repeat (900) @(negedge clk);
    check1("txen_off_txemt", bus.TxEMT, 1);
    TxEN = 1'b1;
    @(negedge clk);
    check1("txen_rise_txrdy", bus.TxRDY, 1);
    check1("txen_rise_txemt", bus.TxEMT, 1);
    TxEN = 1'b0;
    @(negedge clk);
    check1("txen_fall_txrdy", bus.TxRDY, 0);
    TxEN = 1'b1;
    @(negedge clk);

    // TxReset pulse during DATA aborts the character
    abort_flag = 1'b1;
    write_thr(8'h00, 1);
    wait_state("abort_reach_data", DATA, 2000);
    repeat (3) @(negedge clk);
    check1("abort_txd_before", TxD, 0);
    TxReset = 1'b0;
    @(negedge clk);
    check1("abort_txd", TxD, 1);
    check1("abort_txrdy", bus.TxRDY, 0);
    check1("abort_txemt", bus.TxEMT, 0);
    check1("abort_state", state_dbg, IDLE);
    TxReset = 1'b1;
    repeat (2) @(negedge clk);
    check1("abort_thr_empty_txrdy", bus.TxRDY, 1);
    check1("abort_txemt_after", bus.TxEMT, 1);
    repeat (700) @(negedge clk);
    exp_q.push_back(12'b001101001100);
    write_thr(8'h96, 1);
    wait_idle("after_abort", rdy_hi);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
